// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the common bus controller.
//   ARB_*       selection mode codes (ARB_MODE parameter values)
//   bus_state_e ownership FSM encoding
//   XFER_W      width of the transfer counter
package bus_pkg;

  localparam int ARB_DIRECT = 0;  // explicit select code
  localparam int ARB_PRIO   = 1;  // fixed priority, lowest index wins
  localparam int ARB_RR     = 2;  // round-robin from pointer

  localparam int XFER_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } bus_state_e;

endpackage

// File: rtl/common_bus_arb.sv
// common_bus_arb: combinational request arbiter.
//   mode    in  2        ARB_PRIO or ARB_RR (anything else behaves as ARB_PRIO)
//   req     in  NUM_SRC  request vector
//   ptr     in  SEL_W    round-robin search start (ignored in priority mode)
//   win     out NUM_SRC  one-hot winner, zero when no request
//   win_vld out 1        at least one request present
module common_bus_arb
  import bus_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [1:0]         mode,
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] win,
  output logic               win_vld
);

  logic [NUM_SRC-1:0] hi_mask;
  logic [NUM_SRC-1:0] hi_req;
  logic [NUM_SRC-1:0] pick;

  // Round-robin as two priority searches: first among requesters at or above
  // the pointer, and if there are none, wrap to the lowest requester overall.
  // x & -x isolates the lowest set bit.
  always_comb begin
    hi_mask = '1;
    if (mode == 2'(ARB_RR))
      hi_mask = ~((NUM_SRC'(1) << ptr) - NUM_SRC'(1));
    hi_req  = req & hi_mask;
    pick    = (|hi_req) ? hi_req : req;
    win     = pick & (~pick + NUM_SRC'(1));
    win_vld = |req;
  end

endmodule

// File: rtl/common_bus_ctrl.sv
// common_bus_ctrl: registered shared-bus controller.
//   clk, rst_n  clock (rising edge) and async active-low reset
//   src_data    NUM_SRC packed DATA_W sources, source i at [i*DATA_W +: DATA_W]
//   src_req     per-source request (arbitrated modes)
//   src_lock    per-source lock: owner keeps the bus while req & lock
//   sel         direct select code (ARB_DIRECT)
//   sel_valid   direct select transfer request (ARB_DIRECT)
//   bus_out     registered bus value
//   bus_valid   bus_out carries a transfer this cycle
//   grant       one-hot owner aligned with bus_out
//   grant_id    binary owner index (0 when idle)
//   sel_err     one-cycle pulse for an out-of-range select code
//   xfer_cnt    number of valid transfers, wraps
module common_bus_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_SRC   = 8,
  parameter int ARB_MODE  = 0,
  parameter int IDLE_ZERO = 1,
  localparam int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0]        src_lock,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_valid,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      bus_valid,
  output logic [NUM_SRC-1:0]        grant,
  output logic [SEL_W-1:0]          grant_id,
  output logic                      sel_err,
  output logic [XFER_W-1:0]         xfer_cnt
);

  bus_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  bus_q, bus_d;
  logic               vld_q, vld_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   gid_q, gid_d;
  logic               err_q, err_d;
  logic [XFER_W-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC-1:0] arb_win;
  logic               arb_vld;
  logic [SEL_W-1:0]   arb_id;
  logic [DATA_W-1:0]  mux;
  logic               sel_in_range;
  logic               owner_hold;

  common_bus_arb #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_arb (
    .mode    (2'(ARB_MODE)),
    .req     (src_req),
    .ptr     (ptr_q),
    .win     (arb_win),
    .win_vld (arb_vld)
  );

  always_comb begin
    arb_id = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (arb_win[i]) arb_id = SEL_W'(i);
  end

  // Zero-extended compare so a power-of-two NUM_SRC is not a constant compare.
  assign sel_in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
  // grant_q is the owner's one-hot while OWNED.
  assign owner_hold   = (state_q == ST_OWNED) && |(grant_q & src_req & src_lock);

  // Ownership / selection: decides this cycle's winner (grant_d, vld_d).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (ARB_MODE == ARB_DIRECT) begin
      state_d = ST_IDLE;
      if (sel_valid) begin
        if (sel_in_range) begin
          grant_d = NUM_SRC'(1) << sel;
          vld_d   = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
      end
    end else begin
      if (owner_hold) begin
        // Locked owner keeps the bus; pointer frozen.
        grant_d = grant_q;
        vld_d   = 1'b1;
      end else if (arb_vld) begin
        // Covers IDLE, unlocked re-arbitration and same-cycle release.
        grant_d = arb_win;
        vld_d   = 1'b1;
        if (ARB_MODE == ARB_RR)
          ptr_d = (arb_id == SEL_W'(NUM_SRC-1)) ? '0 : arb_id + SEL_W'(1);
      end
      state_d = vld_d ? ST_OWNED : ST_IDLE;
    end
  end

  // Data path: AND-OR mux driven by the one-hot winner.
  always_comb begin
    mux   = '0;
    gid_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_d[i]) begin
        mux   = mux | src_data[i*DATA_W +: DATA_W];
        gid_d = SEL_W'(i);
      end
    end
    if (vld_d)               bus_d = mux;
    else if (IDLE_ZERO != 0) bus_d = '0;
    else                     bus_d = bus_q;
    cnt_d = cnt_q + XFER_W'(vld_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      bus_q   <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
      gid_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bus_q   <= bus_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_out   = bus_q;
  assign bus_valid = vld_q;
  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign sel_err   = err_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_common_bus_ctrl.sv
// Bench for common_bus_ctrl: four instances (direct/8, direct/6, priority/4
// with hold-last, round-robin/4) checked against a per-cycle reference model.
module tb_common_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // direct select, 8 sources
  logic [63:0] d0;   logic [7:0] req0, lock0; logic [2:0] sel0; logic sv0;
  logic [7:0]  bo0;  logic bv0; logic [7:0] g0; logic [2:0] gi0; logic se0; logic [15:0] xc0;
  // direct select, 6 sources
  logic [47:0] d6;   logic [5:0] req6, lock6; logic [2:0] sel6; logic sv6;
  logic [7:0]  bo6;  logic bv6; logic [5:0] g6; logic [2:0] gi6; logic se6; logic [15:0] xc6;
  // fixed priority, 4 sources, hold last value
  logic [31:0] dp;   logic [3:0] reqp, lockp; logic [1:0] selp; logic svp;
  logic [7:0]  bop;  logic bvp; logic [3:0] gp; logic [1:0] gip; logic sep; logic [15:0] xcp;
  // round-robin, 4 sources
  logic [31:0] dr;   logic [3:0] reqr, lockr; logic [1:0] selr; logic svr;
  logic [7:0]  bor;  logic bvr; logic [3:0] gr; logic [1:0] gir; logic ser; logic [15:0] xcr;

  // expected values
  logic [7:0] x0_bus; logic x0_vld; logic [7:0] x0_gnt; logic [2:0] x0_id; logic x0_err; logic [15:0] x0_cnt;
  logic [7:0] x6_bus; logic x6_vld; logic [5:0] x6_gnt; logic [2:0] x6_id; logic x6_err; logic [15:0] x6_cnt;
  logic [7:0] xp_bus; logic xp_vld; logic [3:0] xp_gnt; logic [1:0] xp_id; logic [15:0] xp_cnt;
  logic [7:0] xr_bus; logic xr_vld; logic [3:0] xr_gnt; logic [1:0] xr_id; logic [15:0] xr_cnt;
  int p_owner, p_ptr, r_owner, r_ptr;

  common_bus_ctrl #(.DATA_W(8), .NUM_SRC(8), .ARB_MODE(0), .IDLE_ZERO(1)) u_m0 (
    .clk(clk), .rst_n(rst_n), .src_data(d0), .src_req(req0), .src_lock(lock0),
    .sel(sel0), .sel_valid(sv0), .bus_out(bo0), .bus_valid(bv0), .grant(g0),
    .grant_id(gi0), .sel_err(se0), .xfer_cnt(xc0));

  common_bus_ctrl #(.DATA_W(8), .NUM_SRC(6), .ARB_MODE(0), .IDLE_ZERO(1)) u_m6 (
    .clk(clk), .rst_n(rst_n), .src_data(d6), .src_req(req6), .src_lock(lock6),
    .sel(sel6), .sel_valid(sv6), .bus_out(bo6), .bus_valid(bv6), .grant(g6),
    .grant_id(gi6), .sel_err(se6), .xfer_cnt(xc6));

  common_bus_ctrl #(.DATA_W(8), .NUM_SRC(4), .ARB_MODE(1), .IDLE_ZERO(0)) u_prio (
    .clk(clk), .rst_n(rst_n), .src_data(dp), .src_req(reqp), .src_lock(lockp),
    .sel(selp), .sel_valid(svp), .bus_out(bop), .bus_valid(bvp), .grant(gp),
    .grant_id(gip), .sel_err(sep), .xfer_cnt(xcp));

  common_bus_ctrl #(.DATA_W(8), .NUM_SRC(4), .ARB_MODE(2), .IDLE_ZERO(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .src_data(dr), .src_req(reqr), .src_lock(lockr),
    .sel(selr), .sel_valid(svr), .bus_out(bor), .bus_valid(bvr), .grant(gr),
    .grant_id(gir), .sel_err(ser), .xfer_cnt(xcr));

  task automatic model_clear();
    x0_bus = '0; x0_vld = 0; x0_gnt = '0; x0_id = '0; x0_err = 0; x0_cnt = '0;
    x6_bus = '0; x6_vld = 0; x6_gnt = '0; x6_id = '0; x6_err = 0; x6_cnt = '0;
    xp_bus = '0; xp_vld = 0; xp_gnt = '0; xp_id = '0; xp_cnt = '0;
    xr_bus = '0; xr_vld = 0; xr_gnt = '0; xr_id = '0; xr_cnt = '0;
    p_owner = -1; p_ptr = 0; r_owner = -1; r_ptr = 0;
  endtask

  // Ownership rules: a locked requesting owner keeps the bus; otherwise the
  // first requester from the search start wins (start = pointer in RR mode).
  task automatic arb_model(input int mode, input logic [3:0] req, input logic [3:0] lock,
                           inout int owner, inout int ptr, output int win);
    int s;
    win = -1;
    if (owner >= 0 && req[owner] && lock[owner]) win = owner;
    else begin
      s = (mode == 2) ? ptr : 0;
      for (int k = 0; k < 4; k++)
        if (win < 0 && req[(s + k) % 4]) win = (s + k) % 4;
      if (win >= 0 && mode == 2) ptr = (win + 1) % 4;
    end
    owner = win;
  endtask

  // Predict every instance from the current inputs, then advance one edge.
  task automatic cycle();
    int w;
    x0_err = 0;
    if (sv0) begin
      x0_bus = d0[int'(sel0)*8 +: 8]; x0_vld = 1; x0_gnt = 8'(1) << sel0; x0_id = sel0; x0_cnt++;
    end else begin
      x0_bus = '0; x0_vld = 0; x0_gnt = '0; x0_id = '0;
    end
    x6_err = sv6 && (int'(sel6) >= 6);
    if (sv6 && int'(sel6) < 6) begin
      x6_bus = d6[int'(sel6)*8 +: 8]; x6_vld = 1; x6_gnt = 6'(1) << sel6; x6_id = sel6; x6_cnt++;
    end else begin
      x6_bus = '0; x6_vld = 0; x6_gnt = '0; x6_id = '0;
    end
    arb_model(1, reqp, lockp, p_owner, p_ptr, w);
    if (w >= 0) begin
      xp_bus = dp[w*8 +: 8]; xp_vld = 1; xp_gnt = 4'(1) << w; xp_id = 2'(w); xp_cnt++;
    end else begin
      xp_vld = 0; xp_gnt = '0; xp_id = '0;
    end
    arb_model(2, reqr, lockr, r_owner, r_ptr, w);
    if (w >= 0) begin
      xr_bus = dr[w*8 +: 8]; xr_vld = 1; xr_gnt = 4'(1) << w; xr_id = 2'(w); xr_cnt++;
    end else begin
      xr_bus = '0; xr_vld = 0; xr_gnt = '0; xr_id = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_clear();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({bo0, bv0, g0, gi0, se0, xc0} !== '0)
      $display("FAIL reset_m0 got %h exp 0", {bo0, bv0, g0, gi0, se0, xc0});
    else n_pass++;
    n_chk++;
    if ({bor, bvr, gr, gir, ser, xcr, bop, bvp, gp, gip, xcp} !== '0)
      $display("FAIL reset_arb got %h exp 0", {bor, bvr, gr, gir, ser, xcr, bop, bvp, gp, gip, xcp});
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_direct();
    d0 = {$urandom, $urandom};
    d0[31:24] = 8'h5A; sel0 = 3'd3; sv0 = 1;
    cycle();
    n_chk++;
    if ({bo0, bv0, g0, gi0, xc0} !== {8'h5A, 1'b1, 8'h08, 3'd3, 16'd1})
      $display("FAIL direct_sel3 got %h exp %h", {bo0, bv0, g0, gi0, xc0}, {8'h5A, 1'b1, 8'h08, 3'd3, 16'd1});
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      d0 = {$urandom, $urandom}; sel0 = 3'($urandom); sv0 = ($urandom_range(3) != 0);
      cycle();
      n_chk++;
      if ({bo0, bv0, g0, gi0, se0, xc0} !== {x0_bus, x0_vld, x0_gnt, x0_id, x0_err, x0_cnt})
        $display("FAIL direct_rand%0d got %h exp %h", i, {bo0, bv0, g0, gi0, se0, xc0},
                 {x0_bus, x0_vld, x0_gnt, x0_id, x0_err, x0_cnt});
      else n_pass++;
    end
    sv0 = 0;
  endtask

  task automatic test_sel_err();
    logic [15:0] cnt_before;
    d6 = {$urandom, 16'($urandom)};
    cnt_before = xc6;
    sel6 = 3'd7; sv6 = 1;
    cycle();
    n_chk++;
    if ({bo6, bv6, se6, g6, xc6} !== {8'h00, 1'b0, 1'b1, 6'h00, cnt_before})
      $display("FAIL sel_err_7 got %h exp %h", {bo6, bv6, se6, g6, xc6}, {8'h00, 1'b0, 1'b1, 6'h00, cnt_before});
    else n_pass++;
    sv6 = 0;
    cycle();
    n_chk++;
    if ({se6, bv6} !== 2'b00) $display("FAIL sel_err_pulse got %b exp 00", {se6, bv6});
    else n_pass++;
    for (int i = 0; i < 24; i++) begin
      d6 = {$urandom, 16'($urandom)}; sel6 = 3'($urandom); sv6 = $urandom_range(1);
      cycle();
      n_chk++;
      if ({bo6, bv6, g6, gi6, se6, xc6} !== {x6_bus, x6_vld, x6_gnt, x6_id, x6_err, x6_cnt})
        $display("FAIL sel6_rand%0d got %h exp %h", i, {bo6, bv6, g6, gi6, se6, xc6},
                 {x6_bus, x6_vld, x6_gnt, x6_id, x6_err, x6_cnt});
      else n_pass++;
    end
    sv6 = 0;
  endtask

  task automatic test_prio();
    dp = $urandom; reqp = 4'b0110; lockp = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_chk++;
      if (gp !== 4'b0010) $display("FAIL prio_hold%0d got %b exp 0010", i, gp);
      else n_pass++;
    end
    reqp = 4'b0100;
    cycle();
    n_chk++;
    if ({gp, gip} !== {4'b0100, 2'd2}) $display("FAIL prio_drop got %h exp %h", {gp, gip}, {4'b0100, 2'd2});
    else n_pass++;
    for (int i = 0; i < 50; i++) begin
      dp = $urandom; reqp = 4'($urandom); lockp = 4'($urandom);
      if ($urandom_range(4) == 0) reqp = '0;
      cycle();
      n_chk++;
      if ({bop, bvp, gp, gip, xcp} !== {xp_bus, xp_vld, xp_gnt, xp_id, xp_cnt})
        $display("FAIL prio_rand%0d got %h exp %h", i, {bop, bvp, gp, gip, xcp},
                 {xp_bus, xp_vld, xp_gnt, xp_id, xp_cnt});
      else n_pass++;
    end
    reqp = '0; lockp = '0;
  endtask

  task automatic test_rr();
    int ids[5] = '{0, 1, 3, 0, 1};
    do_reset();
    dr = $urandom; reqr = 4'b1011; lockr = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_chk++;
      if ({bvr, gir} !== {1'b1, 2'(ids[i])}) $display("FAIL rr_seq%0d got %h exp %h", i, {bvr, gir}, {1'b1, 2'(ids[i])});
      else n_pass++;
    end
    reqr = 4'b0101; lockr = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_chk++;
      if (gr !== 4'b0100) $display("FAIL rr_lock%0d got %b exp 0100", i, gr);
      else n_pass++;
    end
    lockr = '0;
    cycle();
    n_chk++;
    if ({gr, bor} !== {4'b0001, dr[7:0]}) $display("FAIL rr_unlock got %h exp %h", {gr, bor}, {4'b0001, dr[7:0]});
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      dr = $urandom; reqr = 4'($urandom); lockr = 4'($urandom);
      cycle();
      n_chk++;
      if ({bor, bvr, gr, gir, xcr} !== {xr_bus, xr_vld, xr_gnt, xr_id, xr_cnt})
        $display("FAIL rr_rand%0d got %h exp %h", i, {bor, bvr, gr, gir, xcr},
                 {xr_bus, xr_vld, xr_gnt, xr_id, xr_cnt});
      else n_pass++;
    end
    reqr = '0; lockr = '0;
  endtask

  task automatic test_reset_mid_lock();
    reqr = 4'b0100; lockr = 4'b0100; dr = $urandom;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bor, bvr, gr, gir, xcr} !== '0) $display("FAIL rst_mid_lock got %h exp 0", {bor, bvr, gr, gir, xcr});
    else n_pass++;
    model_clear();
    reqr = '0; lockr = '0;
    @(negedge clk) rst_n = 1'b1;
    cycle();
    n_chk++;
    if ({bvr, gr, xcr} !== '0) $display("FAIL rst_release got %h exp 0", {bvr, gr, xcr});
    else n_pass++;
    // pointer must be back at 0: source 0 beats source 3
    reqr = 4'b1001;
    cycle();
    n_chk++;
    if ({gr, xcr} !== {4'b0001, 16'd1}) $display("FAIL rst_ptr got %h exp %h", {gr, xcr}, {4'b0001, 16'd1});
    else n_pass++;
    reqr = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    sv0 = 1; sel0 = 3'd5; d0 = {$urandom, $urandom};
    for (int i = 0; i < 65535; i++) cycle();
    n_chk++;
    if ({xc0, x0_cnt} !== {16'hFFFF, 16'hFFFF}) $display("FAIL cnt_max got %h exp ffff", xc0);
    else n_pass++;
    cycle();
    n_chk++;
    if ({xc0, bv0} !== {16'h0000, 1'b1}) $display("FAIL cnt_wrap got %h exp %h", {xc0, bv0}, {16'h0000, 1'b1});
    else n_pass++;
    sv0 = 0;
    cycle();
    n_chk++;
    if ({xc0, bv0, bo0} !== {16'h0000, 1'b0, 8'h00}) $display("FAIL cnt_idle got %h exp 0", {xc0, bv0, bo0});
    else n_pass++;
  endtask

  initial begin
    d0 = '0; req0 = '0; lock0 = '0; sel0 = '0; sv0 = 0;
    d6 = '0; req6 = '0; lock6 = '0; sel6 = '0; sv6 = 0;
    dp = '0; reqp = '0; lockp = '0; selp = '0; svp = 0;
    dr = '0; reqr = '0; lockr = '0; selr = '0; svr = 0;
    model_clear();
    test_reset();
    test_direct();
    test_sel_err();
    test_prio();
    test_rr();
    test_reset_mid_lock();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/common_bus_ctrl.md
Name: common_bus_ctrl

Overview:
- Parametrised, registered common-bus controller. It is the next generation of the combinational 8-way bus selector.
- Drives one DATA_W-bit shared bus from NUM_SRC register/memory sources.
- Selection is either by explicit select code or by request-based arbitration (fixed priority or round-robin), with bus locking for multi-cycle ownership.
- Sits between the datapath registers (AR, PC, DR, AC, IR, RAM) and all bus loads. It adds a registered output, a valid flag, grant reporting and a transfer counter.

Parameters:
- DATA_W, 8, bus width in bits. Narrower sources (AR, PC) are zero-extended by the instantiating parent.
- NUM_SRC, 8, number of sources; legal range 2..16.
- ARB_MODE, 0, selection mode: 0 = direct select, 1 = fixed priority (lowest index wins), 2 = round-robin.
- IDLE_ZERO, 1, bus_out behaviour when no transfer: 1 = drive 0, 0 = hold last value.
- SEL_W, $clog2(NUM_SRC), localparam; width of select and id fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_data  in  NUM_SRC*DATA_W  packed sources; source i occupies [i*DATA_W +: DATA_W].
- src_req  in  NUM_SRC  per-source bus request; used in modes 1 and 2.
- src_lock  in  NUM_SRC  per-source lock; owner keeps the bus while its req and lock are both high (modes 1 and 2).
- sel  in  SEL_W  source select code (mode 0).
- sel_valid  in  1  direct-select transfer request (mode 0).
- bus_out  out  DATA_W  registered bus value.
- bus_valid  out  1  bus_out holds a transfer this cycle.
- grant  out  NUM_SRC  one-hot owner, aligned with bus_out.
- grant_id  out  SEL_W  binary index of the owner.
- sel_err  out  1  one-cycle pulse: mode 0 select code >= NUM_SRC.
- xfer_cnt  out  16  count of valid transfers; wraps 0xFFFF -> 0.

Behaviour:
- Reset: rst_n low asynchronously clears bus_out, bus_valid, grant, grant_id, sel_err, xfer_cnt, the round-robin pointer and the FSM (to IDLE). Release is synchronised externally.
- Latency: winner and data are sampled at edge k and appear on bus_out, grant and bus_valid after edge k (1 cycle).
- Mode 0:
  - sel_valid=1 and sel<NUM_SRC: transfer from source sel.
  - sel_valid=1 and sel>=NUM_SRC: no transfer, sel_err=1 for one cycle.
  - src_req and src_lock are ignored.
- Mode 1: winner is the lowest index with src_req set.
- Mode 2:
  - Search starts at pointer and wraps modulo NUM_SRC; first requester wins.
  - After each grant, pointer = winner+1 (wraps from NUM_SRC-1 to 0).
  - Reset pointer = 0.
- FSM (modes 1 and 2):
  - IDLE: no owner. Any request -> arbitrate, grant, go to OWNED.
  - OWNED, owner req&lock=1: owner retained regardless of other requests; pointer not advanced.
  - OWNED, owner lock=0 and req=1: re-arbitrate every cycle (owner may win again per mode rules).
  - OWNED, owner req=0: release in the same cycle. Re-arbitrate among the rest; if none, go to IDLE.
  - In mode 0 the FSM stays in IDLE.
- No transfer: bus_valid=0 and grant=0. bus_out=0 if IDLE_ZERO=1, otherwise bus_out holds its last value.
- xfer_cnt increments on every cycle in which bus_valid is registered as 1.
- Simultaneous lock assertion by a non-owner has no effect until that source wins.
- Reset mid-lock: ownership is lost, FSM returns to IDLE, no transfer is reported after reset.
- grant is always one-hot or zero; grant_id is undefined-free (0 when idle).

Decomposition:
- Package bus_pkg: ARB_DIRECT/ARB_PRIO/ARB_RR mode constants, FSM state encoding (IDLE, OWNED), transfer counter width constant (16).
- Sub-module common_bus_arb: combinational arbiter taking req, pointer and mode, returning a one-hot winner and a valid flag.
- Top-level common_bus_ctrl holds the FSM, pointer, data mux and output registers.

Test Plan:
1. Mode 0, NUM_SRC=8: src3=0x5A, sel=3, sel_valid=1 -> after 1 edge: bus_out=0x5A, bus_valid=1, grant=0x08, grant_id=3, xfer_cnt=1.
2. Mode 0, NUM_SRC=6, sel=7 -> bus_valid=0, sel_err pulses 1 for one cycle, xfer_cnt unchanged; bus_out=0 (IDLE_ZERO=1).
3. Mode 1: src_req=0b0110 held 3 cycles -> grant=0x02 each cycle. Drop req1 -> next cycle grant=0x04.
4. Mode 2: src_req=0b1011 held -> grant_ids 0,1,3,0,1 on consecutive cycles.
5. Mode 2: src2 req+lock for 4 cycles while src0 requests -> grant=0x04 for 4 cycles. Drop lock -> src0 granted next (pointer=3, wrap to 0).
6. Assert rst_n=0 mid-lock, between clock edges -> outputs 0 immediately. After release with src_req=0: bus_valid=0 and FSM in IDLE. Separately, preload/run 65536 transfers -> xfer_cnt wraps to 0.
